// File: rtl/riscv_pkg.sv
// ============================================================================
//  riscv_pkg : shared types and widths for the execute stage
//  Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int C_WIDTH = 32;
    localparam int C_REG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG     = 2'd0,
        FWD_EXMEM   = 2'd1,
        FWD_MEMWB   = 2'd2,
        FWD_REG_ALT = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        SRCA_REG  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2
    } srca_sel_t;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } srcb_sel_t;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        alu_op_t   alu_op;
        srca_sel_t srca_sel;
        srcb_sel_t srcb_sel;
        logic      is_div;
        div_op_t   div_op;
    } EX_ctrl;

endpackage

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  div_unit : iterative restoring divider, one quotient bit per cycle
//  Rev 1.0
// ============================================================================
`default_nettype none

module div_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH = C_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_kill,
    input  div_op_t          i_op,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_is_rem;

    logic             w_load;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_dvs_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_signed   = (i_op == OP_DIV) || (i_op == OP_REM);
    assign w_a_neg    = w_signed & i_dividend[WIDTH-1];
    assign w_b_neg    = w_signed & i_divisor[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_abs    = w_b_neg ? -i_divisor : i_divisor;
    assign w_dvs_zero = (i_divisor == '0);
    assign w_ovf      = w_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_divisor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_load = 1'b1;
                    o_busy = 1'b1;
                    w_next = (w_dvs_zero || w_ovf) ? DONE : BUSY;
                end
            end
            BUSY: begin
                o_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (i_kill) begin
            w_next = IDLE;
            w_load = 1'b0;
            o_busy = 1'b0;
            o_done = 1'b0;
        end
        // Outputs must fall the moment reset asserts, not at the next edge
        if (!rst_n) begin
            o_busy = 1'b0;
            o_done = 1'b0;
        end
    end

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit   = ~w_diff[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_rem <= 1'b0;
        end else if (w_load) begin
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_is_rem <= (i_op == OP_REM) || (i_op == OP_REMU);
            r_dvs    <= w_b_abs;
            if (w_dvs_zero) begin
                r_quo   <= '1;
                r_rem   <= i_dividend;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else if (w_ovf) begin
                r_quo   <= {1'b1, {(WIDTH-1){1'b0}}};
                r_rem   <= '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_quo   <= w_a_abs;
                r_rem   <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
        end else if (r_state == BUSY) begin
            r_quo <= {r_quo[WIDTH-2:0], w_qbit};
            r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;
    assign o_result = o_done ? (r_is_rem ? w_r_fix : w_q_fix) : '0;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
//  ex_stage : execute stage - forwarding, ALU and optional divider
//  Divider built only when RV_DIV_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module ex_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int REG_W = C_REG_W
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             valid_in,
    input  logic             kill_in,
    input  EX_ctrl           EXctrl_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] imm_in,
    input  logic [WIDTH-1:0] rs1_data_in,
    input  logic [WIDTH-1:0] rs2_data_in,
    input  fwd_sel_t         fwd_a_sel,
    input  fwd_sel_t         fwd_b_sel,
    input  logic [WIDTH-1:0] exmem_fwd_data,
    input  logic [WIDTH-1:0] memwb_fwd_data,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic             result_valid,
    output logic             stall_out
);

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;
    logic [REG_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_result;
    logic             w_valid;
    logic             w_stall;

    always_comb begin
        case (fwd_a_sel)
            FWD_EXMEM: w_op_a = exmem_fwd_data;
            FWD_MEMWB: w_op_a = memwb_fwd_data;
            default:   w_op_a = rs1_data_in;
        endcase
        case (fwd_b_sel)
            FWD_EXMEM: w_op_b = exmem_fwd_data;
            FWD_MEMWB: w_op_b = memwb_fwd_data;
            default:   w_op_b = rs2_data_in;
        endcase
    end

    always_comb begin
        case (EXctrl_in.srca_sel)
            SRCA_PC:   w_src_a = pc_in;
            SRCA_ZERO: w_src_a = '0;
            default:   w_src_a = w_op_a;
        endcase
        case (EXctrl_in.srcb_sel)
            SRCB_IMM:  w_src_b = imm_in;
            SRCB_FOUR: w_src_b = WIDTH'(4);
            default:   w_src_b = w_op_b;
        endcase
    end

    assign w_shamt = w_src_b[REG_W-1:0];

    always_comb begin
        case (EXctrl_in.alu_op)
            ALU_ADD:    w_alu = w_src_a + w_src_b;
            ALU_SUB:    w_alu = w_src_a - w_src_b;
            ALU_AND:    w_alu = w_src_a & w_src_b;
            ALU_OR:     w_alu = w_src_a | w_src_b;
            ALU_XOR:    w_alu = w_src_a ^ w_src_b;
            ALU_SLT:    w_alu = {{(WIDTH-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
            ALU_SLTU:   w_alu = {{(WIDTH-1){1'b0}}, w_src_a < w_src_b};
            ALU_SLL:    w_alu = w_src_a << w_shamt;
            ALU_SRL:    w_alu = w_src_a >> w_shamt;
            ALU_SRA:    w_alu = $signed(w_src_a) >>> w_shamt;
            ALU_PASS_B: w_alu = w_src_b;
            default:    w_alu = '0;
        endcase
    end

`ifdef RV_DIV_EN
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_result;

    // Dividend/divisor are the forwarded register values; immediates never feed a divide
    div_unit #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk        (CLK),
        .rst_n      (RSTn),
        .i_start    (valid_in & EXctrl_in.is_div),
        .i_kill     (kill_in),
        .i_op       (EXctrl_in.div_op),
        .i_dividend (w_op_a),
        .i_divisor  (w_op_b),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_result   (w_div_result)
    );

    assign w_stall  = w_div_busy;
    assign w_valid  = EXctrl_in.is_div ? w_div_done : valid_in;
    assign w_result = EXctrl_in.is_div ? w_div_result : w_alu;
`else
    logic w_unused_nodiv;
    assign w_unused_nodiv = ^{CLK, kill_in, EXctrl_in.div_op};

    assign w_stall  = 1'b0;
    assign w_valid  = valid_in;
    assign w_result = EXctrl_in.is_div ? '0 : w_alu;
`endif

    assign result_out     = RSTn ? w_result : '0;
    assign store_data_out = RSTn ? w_op_b : '0;
    assign result_valid   = RSTn & w_valid;
    assign stall_out      = RSTn & w_stall;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
//  tb_ex_stage : directed self-checking bench for ex_stage
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage;
    import riscv_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [3:0]   op;
        logic [1:0]   sa;
        logic [1:0]   sb;
        logic [1:0]   fa;
        logic [1:0]   fb;
        logic [W-1:0] pc;
        logic [W-1:0] imm;
        logic [W-1:0] rs1;
        logic [W-1:0] rs2;
        logic [W-1:0] exm;
        logic [W-1:0] mwb;
        logic [W-1:0] res;
        logic [W-1:0] st;
    } alu_vec_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           stalls;
        logic [W-1:0] res;
    } div_vec_t;

    logic         CLK;
    logic         RSTn;
    logic         valid_in;
    logic         kill_in;
    EX_ctrl       ctrl;
    logic [W-1:0] pc_in;
    logic [W-1:0] imm_in;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    fwd_sel_t     fa;
    fwd_sel_t     fb;
    logic [W-1:0] exm;
    logic [W-1:0] mwb;
    logic [W-1:0] result_out;
    logic [W-1:0] store_data_out;
    logic         result_valid;
    logic         stall_out;

    int n_cmp = 0;
    int n_bad = 0;

    ex_stage #(
        .WIDTH(W),
        .REG_W(5)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .valid_in       (valid_in),
        .kill_in        (kill_in),
        .EXctrl_in      (ctrl),
        .pc_in          (pc_in),
        .imm_in         (imm_in),
        .rs1_data_in    (rs1),
        .rs2_data_in    (rs2),
        .fwd_a_sel      (fa),
        .fwd_b_sel      (fb),
        .exmem_fwd_data (exm),
        .memwb_fwd_data (mwb),
        .result_out     (result_out),
        .store_data_out (store_data_out),
        .result_valid   (result_valid),
        .stall_out      (stall_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_idle();
        valid_in      = 1'b0;
        kill_in       = 1'b0;
        ctrl.alu_op   = ALU_ADD;
        ctrl.srca_sel = SRCA_REG;
        ctrl.srcb_sel = SRCB_REG;
        ctrl.is_div   = 1'b0;
        ctrl.div_op   = OP_DIV;
        fa = FWD_REG;  fb = FWD_REG;
        pc_in = '0; imm_in = '0; rs1 = '0; rs2 = '0; exm = '0; mwb = '0;
    endtask

    task automatic drive_div(input div_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        drive_idle();
        valid_in    = 1'b1;
        ctrl.is_div = 1'b1;
        ctrl.div_op = op;
        rs1 = a; rs2 = b;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        drive_idle();
        valid_in = 1'b1; rs1 = 32'h5; rs2 = 32'h6;
        repeat (2) @(negedge CLK);
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", result_valid); end
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", stall_out); end
        n_cmp++; if (result_out !== 32'h0) begin n_bad++; $display("FAIL rst_result: got %h expected 0", result_out); end
        n_cmp++; if (store_data_out !== 32'h0) begin n_bad++; $display("FAIL rst_store: got %h expected 0", store_data_out); end
        drive_idle();
        #2 RSTn = 1'b1;
        @(negedge CLK);
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b expected 0", result_valid); end
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL post_rst_stall: got %b expected 0", stall_out); end
    endtask

    task automatic test_alu();
        alu_vec_t tbl[15];
        tbl[0]  = '{ALU_ADD,    SRCA_REG,  SRCB_IMM,  FWD_EXMEM,   FWD_REG,   32'h0, 32'h5, 32'h1234, 32'h77, 32'h10, 32'h0, 32'h15, 32'h77};
        tbl[1]  = '{ALU_SRA,    SRCA_REG,  SRCB_IMM,  FWD_REG,     FWD_REG,   32'h0, 32'h4, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'hF800_0000, 32'h0};
        tbl[2]  = '{ALU_SLTU,   SRCA_REG,  SRCB_REG,  FWD_REG,     FWD_REG,   32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF};
        tbl[3]  = '{ALU_SLT,    SRCA_REG,  SRCB_REG,  FWD_REG,     FWD_REG,   32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        tbl[4]  = '{ALU_SUB,    SRCA_REG,  SRCB_REG,  FWD_REG,     FWD_REG,   32'h0, 32'h0, 32'h3, 32'h5, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h5};
        tbl[5]  = '{ALU_AND,    SRCA_REG,  SRCB_REG,  FWD_REG,     FWD_MEMWB, 32'h0, 32'h0, 32'h0F0F_0F0F, 32'hDEAD, 32'h0, 32'h00FF_00FF, 32'h000F_000F, 32'h00FF_00FF};
        tbl[6]  = '{ALU_ADD,    SRCA_PC,   SRCB_FOUR, FWD_REG,     FWD_REG,   32'h1000, 32'h0, 32'h0, 32'h9, 32'h0, 32'h0, 32'h1004, 32'h9};
        tbl[7]  = '{ALU_ADD,    SRCA_ZERO, SRCB_IMM,  FWD_REG,     FWD_REG,   32'h0, 32'hABCD_E000, 32'h55, 32'h0, 32'h0, 32'h0, 32'hABCD_E000, 32'h0};
        tbl[8]  = '{ALU_SLL,    SRCA_REG,  SRCB_REG,  FWD_REG,     FWD_REG,   32'h0, 32'h0, 32'h1, 32'h3F, 32'h0, 32'h0, 32'h8000_0000, 32'h3F};
        tbl[9]  = '{ALU_SRL,    SRCA_REG,  SRCB_IMM,  FWD_REG_ALT, FWD_REG,   32'h0, 32'h1F, 32'h8000_0000, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0};
        tbl[10] = '{ALU_XOR,    SRCA_REG,  SRCB_REG,  FWD_MEMWB,   FWD_EXMEM, 32'h0, 32'h0, 32'h0, 32'h0F0F_0F0F, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 32'h1234_5678};
        tbl[11] = '{ALU_OR,     SRCA_REG,  SRCB_REG,  FWD_REG,     FWD_REG,   32'h0, 32'h0, 32'hF0, 32'h0F, 32'h0, 32'h0, 32'hFF, 32'h0F};
        tbl[12] = '{ALU_PASS_B, SRCA_REG,  SRCB_IMM,  FWD_REG,     FWD_REG,   32'h0, 32'hCAFE_BABE, 32'h1, 32'h2, 32'h0, 32'h0, 32'hCAFE_BABE, 32'h2};
        tbl[13] = '{ALU_ADD,    SRCA_REG,  SRCB_REG,  FWD_REG,     FWD_REG,   32'h0, 32'h0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, 32'h1, 32'h2};
        tbl[14] = '{ALU_SRA,    SRCA_REG,  SRCB_REG,  FWD_REG,     FWD_REG,   32'h0, 32'h0, 32'h7FFF_FFF0, 32'h4, 32'h0, 32'h0, 32'h07FF_FFFF, 32'h4};
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK); #1;
            drive_idle();
            valid_in      = 1'b1;
            ctrl.alu_op   = alu_op_t'(tbl[i].op);
            ctrl.srca_sel = srca_sel_t'(tbl[i].sa);
            ctrl.srcb_sel = srcb_sel_t'(tbl[i].sb);
            fa = fwd_sel_t'(tbl[i].fa);  fb = fwd_sel_t'(tbl[i].fb);
            pc_in = tbl[i].pc; imm_in = tbl[i].imm; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
            exm = tbl[i].exm; mwb = tbl[i].mwb;
            @(negedge CLK);
            n_cmp++; if (result_out !== tbl[i].res) begin n_bad++; $display("FAIL alu%0d_result: got %h expected %h", i, result_out, tbl[i].res); end
            n_cmp++; if (store_data_out !== tbl[i].st) begin n_bad++; $display("FAIL alu%0d_store: got %h expected %h", i, store_data_out, tbl[i].st); end
            n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL alu%0d_valid: got %b expected 1", i, result_valid); end
            n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL alu%0d_stall: got %b expected 0", i, stall_out); end
        end
        @(posedge CLK); #1;
        drive_idle();
    endtask

    task automatic test_back_to_back();
        @(posedge CLK); #1;
        drive_idle(); valid_in = 1'b1; rs1 = 32'h1; rs2 = 32'h2;
        @(negedge CLK);
        n_cmp++; if (result_out !== 32'h3) begin n_bad++; $display("FAIL b2b_add: got %h expected 3", result_out); end
        @(posedge CLK); #1;
        ctrl.alu_op = ALU_SUB; rs1 = 32'hA; rs2 = 32'h4;
        @(negedge CLK);
        n_cmp++; if (result_out !== 32'h6) begin n_bad++; $display("FAIL b2b_sub: got %h expected 6", result_out); end
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b expected 1", result_valid); end
        @(posedge CLK); #1;
        valid_in = 1'b0;
        @(negedge CLK);
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_valid: got %b expected 0", result_valid); end
        @(posedge CLK); #1;
        drive_div(OP_DIV, 32'h64, 32'h7);
        valid_in = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL bubble_div_stall: got %b expected 0", stall_out); end
            n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_div_valid: got %b expected 0", result_valid); end
        end
        @(posedge CLK); #1;
        drive_idle();
    endtask

    task automatic test_divide();
        div_vec_t tbl[13];
        int       n_stall;
        bit       got;
        int       exp_st;
        logic [W-1:0] exp_r;
        tbl[0]  = '{OP_DIV,  32'hFFFF_FFF9, 32'h2,         33, 32'hFFFF_FFFD};
        tbl[1]  = '{OP_REM,  32'hFFFF_FFF9, 32'h2,         33, 32'hFFFF_FFFF};
        tbl[2]  = '{OP_DIVU, 32'h5,         32'h0,          1, 32'hFFFF_FFFF};
        tbl[3]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  1, 32'h8000_0000};
        tbl[4]  = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  1, 32'h0};
        tbl[5]  = '{OP_DIVU, 32'd100,       32'd7,         33, 32'hE};
        tbl[6]  = '{OP_REMU, 32'd100,       32'd7,         33, 32'h2};
        tbl[7]  = '{OP_DIV,  32'h7,         32'hFFFF_FFFE, 33, 32'hFFFF_FFFD};
        tbl[8]  = '{OP_REM,  32'h7,         32'hFFFF_FFFE, 33, 32'h1};
        tbl[9]  = '{OP_REM,  32'hFFFF_FFF9, 32'h0,          1, 32'hFFFF_FFF9};
        tbl[10] = '{OP_DIVU, 32'hFFFF_FFFF, 32'h1,         33, 32'hFFFF_FFFF};
        tbl[11] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0};
        tbl[12] = '{OP_DIV,  32'h8000_0000, 32'h2,         33, 32'hC000_0000};
        for (int i = 0; i < 13; i++) begin
`ifdef RV_DIV_EN
            exp_st = tbl[i].stalls;
            exp_r  = tbl[i].res;
`else
            exp_st = 0;
            exp_r  = 32'h0;
`endif
            @(posedge CLK); #1;
            drive_div(div_op_t'(tbl[i].op), tbl[i].a, tbl[i].b);
            n_stall = 0;
            got     = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge CLK);
                if (result_valid === 1'b1) begin
                    got = 1'b1;
                    n_cmp++; if (result_out !== exp_r) begin n_bad++; $display("FAIL div%0d_result: got %h expected %h", i, result_out, exp_r); end
                    n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL div%0d_done_stall: got %b expected 0", i, stall_out); end
                end else if (stall_out === 1'b1) begin
                    n_stall++;
                end
                @(posedge CLK); #1;
            end
            drive_idle();
            n_cmp++; if (!got) begin n_bad++; $display("FAIL div%0d_timeout: got no result_valid expected one within 40 cycles", i); end
            n_cmp++; if (n_stall != exp_st) begin n_bad++; $display("FAIL div%0d_stalls: got %0d expected %0d", i, n_stall, exp_st); end
        end
    endtask

    task automatic test_kill();
        @(posedge CLK); #1;
        drive_div(OP_DIV, 32'hFFFF_FFF9, 32'h2);
`ifdef RV_DIV_EN
        repeat (10) @(posedge CLK);
        #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL kill_pre_stall: got %b expected 1", stall_out); end
        kill_in = 1'b1;
        @(negedge CLK);
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL kill_stall: got %b expected 0", stall_out); end
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL kill_valid: got %b expected 0", result_valid); end
        @(posedge CLK); #1;
        drive_idle();
        repeat (3) begin
            @(negedge CLK);
            n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL kill_after_stall: got %b expected 0", stall_out); end
            n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL kill_after_valid: got %b expected 0", result_valid); end
        end
`else
        kill_in = 1'b1;
        @(negedge CLK);
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL kill_stall: got %b expected 0", stall_out); end
        n_cmp++; if (result_out !== 32'h0) begin n_bad++; $display("FAIL kill_nodiv_result: got %h expected 0", result_out); end
`endif
        @(posedge CLK); #1;
        drive_idle(); valid_in = 1'b1; rs1 = 32'h20; rs2 = 32'h22;
        @(negedge CLK);
        n_cmp++; if (result_out !== 32'h42) begin n_bad++; $display("FAIL kill_next_add: got %h expected 42", result_out); end
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL kill_next_valid: got %b expected 1", result_valid); end
        @(posedge CLK); #1;
        drive_idle();
    endtask

    task automatic test_async_reset();
        logic         exp_busy;
        logic         exp_first_valid;
        logic [W-1:0] exp_res;
`ifdef RV_DIV_EN
        exp_busy = 1'b1; exp_first_valid = 1'b0; exp_res = 32'hFFFF_FFFF;
`else
        exp_busy = 1'b0; exp_first_valid = 1'b1; exp_res = 32'h0;
`endif
        @(posedge CLK); #1;
        drive_div(OP_DIV, 32'hFFFF_FFF9, 32'h2);
        repeat (5) @(posedge CLK);
        #1;
        n_cmp++; if (stall_out !== exp_busy) begin n_bad++; $display("FAIL arst_pre_stall: got %b expected %b", stall_out, exp_busy); end
        #1 RSTn = 1'b0;
        #1;
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL arst_stall: got %b expected 0", stall_out); end
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b expected 0", result_valid); end
        n_cmp++; if (result_out !== 32'h0) begin n_bad++; $display("FAIL arst_result: got %h expected 0", result_out); end
        @(posedge CLK); #1;
        drive_idle();
        #2 RSTn = 1'b1;
        @(negedge CLK);
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL arst_release_stall: got %b expected 0", stall_out); end
        @(posedge CLK); #1;
        drive_div(OP_DIVU, 32'h5, 32'h0);
        @(negedge CLK);
        n_cmp++; if (stall_out !== exp_busy) begin n_bad++; $display("FAIL arst_restart_stall: got %b expected %b", stall_out, exp_busy); end
        n_cmp++; if (result_valid !== exp_first_valid) begin n_bad++; $display("FAIL arst_restart_valid0: got %b expected %b", result_valid, exp_first_valid); end
`ifdef RV_DIV_EN
        @(posedge CLK); #1;
        @(negedge CLK);
`endif
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL arst_restart_valid: got %b expected 1", result_valid); end
        n_cmp++; if (result_out !== exp_res) begin n_bad++; $display("FAIL arst_restart_result: got %h expected %h", result_out, exp_res); end
        @(posedge CLK); #1;
        drive_idle();
    endtask

    initial begin
        RSTn = 1'b0;
        drive_idle();
        test_reset();
        test_alu();
        test_back_to_back();
        test_divide();
        test_kill();
        test_async_reset();
        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
